// File: rtl/signal_pulser_pkg.sv
// Shared definitions for the event pulser: FSM state encodings and polarity helpers
// that translate between physical pin levels and logical "active" flags.
package signal_pulser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic logic is_active(input logic lvl, input logic active_low);
        return lvl ^ active_low;
    endfunction

    function automatic logic drive_level(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

    function automatic logic inactive_level(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/signal_pulser_if.sv
// Event-in / stretched-pulse-out bundle of the pulser; the master side raises events
// and observes the output, the slave side is the pulser itself.
interface signal_pulser_if #(
    parameter int MAX_PENDING = 7
);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    logic              in_sig;
    logic              out_sig;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output in_sig,
        input  out_sig,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  in_sig,
        output out_sig,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/signal_edge_detect.sv
// Turns an inactive->active transition of a sys_clk-synchronous level into a single-cycle
// rise pulse; a held active level yields exactly one pulse.
module signal_edge_detect
    import signal_pulser_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // History is kept as a logical "was active" flag, so reset means inactive for either polarity.
    always_comb begin
        prev_d = is_active(sig, ACTIVE_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = prev_d & ~prev_q;

endmodule

// File: rtl/signal_pulser.sv
// Stretches one-cycle events into ON_COUNT-cycle active bursts separated by OFF_COUNT-cycle
// gaps, queueing up to MAX_PENDING events that arrive while a burst or gap is in progress.
module signal_pulser
    import signal_pulser_pkg::*;
#(
    parameter int ON_COUNT       = 65536,
    parameter int OFF_COUNT      = 65536,
    parameter int MAX_PENDING    = 7,
    parameter bit IN_ACTIVE_LOW  = 1'b0,
    parameter bit OUT_ACTIVE_LOW = 1'b1
) (
    input  logic           sys_clk,
    input  logic           rst_n,
    signal_pulser_if.slave bus
);

    localparam int PEND_W   = $clog2(MAX_PENDING + 1);
    localparam int MAX_CNT  = (ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT;
    localparam int CTR_SIZE = $clog2(MAX_CNT);
    localparam int CTR_W    = (CTR_SIZE < 1) ? 1 : CTR_SIZE;

    localparam logic [CTR_W-1:0]  ON_LAST  = CTR_W'(ON_COUNT - 1);
    localparam logic [CTR_W-1:0]  OFF_LAST = CTR_W'(OFF_COUNT - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    if (ON_COUNT < 1 || OFF_COUNT < 1 || MAX_PENDING < 1) begin : g_bad_params
        $error("signal_pulser: ON_COUNT, OFF_COUNT and MAX_PENDING must all be >= 1");
    end

    logic rise;

    signal_edge_detect #(
        .ACTIVE_LOW (IN_ACTIVE_LOW)
    ) u_edge (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .sig   (bus.in_sig),
        .rise  (rise)
    );

    state_e            state_q, state_d;
    logic [CTR_W-1:0]  ctr_q, ctr_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              out_q, out_d;
    logic              dequeue;
    logic              queued_evt;

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        pend_d     = pend_q;
        ovf_d      = 1'b0;
        dequeue    = 1'b0;
        queued_evt = rise && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_ON;
                    ctr_d   = '0;
                end
            end
            ST_ON: begin
                if (ctr_q == ON_LAST) begin
                    state_d = ST_GAP;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            ST_GAP: begin
                if (ctr_q == OFF_LAST) begin
                    ctr_d = '0;
                    if (pend_q != '0) begin
                        state_d = ST_ON;
                        dequeue = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctr_d   = '0;
            end
        endcase

        // A new event landing on a dequeue cycle takes the freed slot, so it can never overflow.
        if (queued_evt && !dequeue) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!queued_evt && dequeue) begin
            pend_d = pend_q - PEND_W'(1);
        end

        busy_d = (state_d != ST_IDLE);
        out_d  = drive_level(state_d == ST_ON, OUT_ACTIVE_LOW);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            out_q   <= inactive_level(OUT_ACTIVE_LOW);
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
        end
    end

    assign bus.out_sig  = out_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pend_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_signal_pulser.sv
// Self-checking bench for signal_pulser (ON=3, OFF=2, MAX_PENDING=2, active-low output):
// per-cycle waveform tables are expanded into vectors and checked through a scoreboard queue.
module tb_signal_pulser;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    always #5 sys_clk = ~sys_clk;

    signal_pulser_if #(.MAX_PENDING(2)) bus ();

    signal_pulser #(
        .ON_COUNT       (3),
        .OFF_COUNT      (2),
        .MAX_PENDING    (2),
        .IN_ACTIVE_LOW  (1'b0),
        .OUT_ACTIVE_LOW (1'b1)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic       out_sig;
        logic       busy;
        logic [1:0] pending;
        logic       overflow;
    } exp_t;

    typedef struct packed {
        logic in_v;
        exp_t want;
    } vec_t;

    localparam exp_t RESET_EXP = '{out_sig: 1'b1, busy: 1'b0, pending: 2'd0, overflow: 1'b0};

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    task automatic checkOutput(input string name, input int cyc);
        exp_t want;
        exp_t got;
        got = {bus.out_sig, bus.busy, bus.pending, bus.overflow};
        checks++;
        if (sb_q.size() == 0) begin
            $display("[TB] FAIL %s cycle %0d: no expected entry queued", name, cyc);
            return;
        end
        want = sb_q.pop_front();
        if (got === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s cycle %0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                     name, cyc, got.out_sig, got.busy, got.pending, got.overflow,
                     want.out_sig, want.busy, want.pending, want.overflow);
        end
    endtask

    task automatic applyStimulus(input logic in_v, input exp_t want);
        bus.in_sig = in_v;
        sb_q.push_back(want);
        @(posedge sys_clk);
        #1;
    endtask

    // Row i of each string is the level in cycle i; input of cycle i predicts outputs of cycle i+1.
    task automatic buildVectors(input string in_s, input string out_s, input string busy_s,
                                input string pend_s, input string ovf_s);
        vecs.delete();
        for (int i = 0; i < in_s.len() - 1; i++) begin
            vec_t v;
            v.in_v          = (in_s[i] == "1");
            v.want.out_sig  = (out_s[i+1] == "1");
            v.want.busy     = (busy_s[i+1] == "1");
            v.want.pending  = 2'(pend_s[i+1] - "0");
            v.want.overflow = (ovf_s[i+1] == "1");
            vecs.push_back(v);
        end
    endtask

    task automatic runVectors(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].in_v, vecs[i].want);
            checkOutput(name, i + 1);
        end
    endtask

    // Leaves the bench at cycle 0 of a fresh run, one time unit after a clock edge.
    task automatic resetDut(input string name);
        rst_n      = 1'b0;
        bus.in_sig = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sb_q.push_back(RESET_EXP);
        checkOutput(name, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_sig = 1'b0;

        resetDut("reset_single");
        buildVectors("000000000010000000",
                     "111111111110001111",
                     "000000000001111100",
                     "000000000000000000",
                     "000000000000000000");
        runVectors("single");

        resetDut("reset_queue");
        buildVectors("0000000000101010000000000000",
                     "1111111111100011000110001111",
                     "0000000000011111111111111100",
                     "0000000000000112111110000000",
                     "0000000000000000000000000000");
        runVectors("queue3");

        // Six events: the fifth finds the queue full, the sixth coincides with a dequeue.
        resetDut("reset_overflow");
        buildVectors("00000000001010101010100000000000000000",
                     "11111111111000110001100011000110001111",
                     "00000000000111111111111111111111111100",
                     "00000000000001121222222222111110000000",
                     "00000000000000000001000000000000000000");
        runVectors("overflow");

        resetDut("reset_held");
        buildVectors("00000000001111111111111111111111111111111000",
                     "11111111111000111111111111111111111111111111",
                     "00000000000111110000000000000000000000000000",
                     "00000000000000000000000000000000000000000000",
                     "00000000000000000000000000000000000000000000");
        runVectors("held");

        // Reset dropped mid-cycle during a burst with one event queued.
        resetDut("reset_async_pre");
        buildVectors("0000000001010",
                     "1111111111000",
                     "0000000000111",
                     "0000000000001",
                     "0000000000000");
        runVectors("async_pre");
        rst_n      = 1'b0;
        bus.in_sig = 1'b0;
        #2;
        sb_q.push_back(RESET_EXP);
        checkOutput("async_reset", 12);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        buildVectors("00000100000",
                     "11111100011",
                     "00000011111",
                     "00000000000",
                     "00000000000");
        runVectors("after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
